// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared state encodings, requester count and round-robin pick
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set request bit found scanning ptr, ptr+1, ... modulo NUM_REQ.
    // The scan runs from the farthest slot back towards ptr, so the nearest hit is written last.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// mux4_w: W-bit 4:1 data multiplexer selected by {S2,S1}
module mux4_w #(
    parameter int W = 8
) (
    input  logic [4*W-1:0] din,
    input  logic           S1,
    input  logic           S2,
    output logic [W-1:0]   dout
);

    // Two-level select tree, identical per bit to the single-bit mux
    always_comb begin
        dout = S2 ? (S1 ? din[3*W +: W] : din[2*W +: W])
                  : (S1 ? din[1*W +: W] : din[0*W +: W]);
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin burst arbiter driving a shared 4:1 data mux
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] din,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [W-1:0]         dout,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 S1,
    output logic                 S2,
    output logic                 busy
);

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       sel;
    logic [1:0]       pick;
    logic [CNT_W-1:0] beat_cnt;
    logic             xfer;
    logic             rel;

    assign sel = {S2, S1};

    mux4_w #(.W(W)) u_mux (
        .din  (din),
        .S1   (S1),
        .S2   (S2),
        .dout (dout)
    );

    // Handshake and release decisions, all derived from the registered select
    always_comb begin
        pick      = rr_pick(req, ptr);
        out_valid = (state == ST_GRANT) && req[sel];
        xfer      = out_valid && out_ready;
        rel       = (state == ST_GRANT) &&
                    (!req[sel] || (xfer && beat_cnt == CNT_W'(MAX_BURST - 1)));
    end

    // Arbitration FSM; select bits hold their value through IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            S1       <= 1'b0;
            S2       <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (|req) begin
                state    <= ST_GRANT;
                gnt      <= 4'b0001 << pick;
                {S2, S1} <= pick;
                busy     <= 1'b1;
                beat_cnt <= '0;
            end
        end else if (rel) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= sel + 2'd1;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed table and sequence checks of the round-robin mux arbiter
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'hF;
    logic        out_ready = 1'b1;
    logic [7:0]  ch [4];
    logic [31:0] din;

    logic       v8, v2, s1_8, s2_8, s1_2, s2_2, b8, b2;
    logic [7:0] d8, d2;
    logic [3:0] g8, g2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t tbl [16];

    assign din = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.W(8), .MAX_BURST(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
        .out_valid(v8), .dout(d8), .gnt(g8), .S1(s1_8), .S2(s2_8), .busy(b8)
    );

    mux4_rr_arbiter #(.W(8), .MAX_BURST(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
        .out_valid(v2), .dout(d2), .gnt(g2), .S1(s1_2), .S2(s2_2), .busy(b2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'h0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'h33; ch[3] = 8'h44;
        // Reset then rotation with MAX_BURST=2: two beats per grant, one idle cycle between
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'hF, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_gnt", i), 32'(g2), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_sel", i), 32'({s2_2, s1_2}), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d_valid", i), 32'(v2), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_busy", i), 32'(b2), 32'(tbl[i].busy));
            if (tbl[i].valid) chk($sformatf("tbl%0d_dout", i), 32'(d2), 32'(ch[tbl[i].sel]));
        end

        // Burst cap: channel 2 alone gets exactly 8 beats, one idle cycle, then regrant
        do_reset();
        req = 4'b0100;
        out_ready = 1'b1;
        step();
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("cap_gnt%0d", b), 32'(g8), 32'h4);
            chk($sformatf("cap_valid%0d", b), 32'(v8), 32'h1);
            chk($sformatf("cap_dout%0d", b), 32'(d8), 32'h33);
            step();
        end
        chk("cap_idle_gnt", 32'(g8), 32'h0);
        chk("cap_idle_valid", 32'(v8), 32'h0);
        step();
        chk("cap_regrant", 32'(g8), 32'h4);
        chk("cap_regrant_sel", 32'({s2_8, s1_8}), 32'h2);

        // Early release: channel 1 drops its request after 3 beats
        do_reset();
        req = 4'b0010;
        step();
        chk("early_gnt", 32'(g8), 32'h2);
        step();
        step();
        step();
        req = 4'b1001;
        #1;
        chk("early_valid_drop", 32'(v8), 32'h0);
        step();
        chk("early_gnt_off", 32'(g8), 32'h0);
        chk("early_busy_off", 32'(b8), 32'h0);
        chk("early_ptr", 32'(dut.ptr), 32'h2);
        req = 4'b1011;
        step();
        chk("early_next_gnt", 32'(g8), 32'h8);

        // Backpressure: stall 5 cycles mid-burst on channel 3
        do_reset();
        ch[3] = 8'hA5;
        req = 4'b1000;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("bp_dout%0d", s), 32'(d8), 32'hA5);
            chk($sformatf("bp_valid%0d", s), 32'(v8), 32'h1);
            chk($sformatf("bp_gnt%0d", s), 32'(g8), 32'h8);
            chk($sformatf("bp_cnt%0d", s), 32'(dut.beat_cnt), 32'h1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_cnt", 32'(dut.beat_cnt), 32'h2);

        // Reset on beat 4 of 8 aborts the burst
        do_reset();
        req = 4'b0001;
        out_ready = 1'b1;
        step();
        step();
        step();
        step();
        chk("rst_mid_before", 32'(g8), 32'h1);
        rst = 1'b1;
        step();
        chk("rst_mid_gnt", 32'(g8), 32'h0);
        chk("rst_mid_valid", 32'(v8), 32'h0);
        chk("rst_mid_ptr", 32'(dut.ptr), 32'h0);
        chk("rst_mid_cnt", 32'(dut.beat_cnt), 32'h0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
